// File: rtl/addsub_serial_if.sv
// Request/result bundle between a sequencer (master) and the digit-serial add/sub unit (slave).
interface addsub_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             op;
   logic             ci;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] r;
   logic             co;
   logic             of;

   modport master (output start, op, ci, x, y, input busy, done, r, co, of);
   modport slave  (input start, op, ci, x, y, output busy, done, r, co, of);
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, N = WIDTH/DIGIT cycles per operation,
// with signed-overflow and carry/borrow flags published only on completion.
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   addsub_serial_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_r;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_op;
   logic             r_busy;
   logic             r_done;
   logic             r_co;
   logic             r_of;

   logic [DIGIT:0]   w_sum;
   logic             w_cOut;
   logic             w_cMsb;
   logic [WIDTH-1:0] w_resNext;

   // One digit slice of the adder; the carry into its MSB is recovered from that sum bit.
   assign w_sum  = {1'b0, r_x[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
   assign w_cOut = w_sum[DIGIT];
   assign w_cMsb = r_x[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];

   // New digits enter at the top, so after N shifts digit 0 has arrived at bit 0.
   assign w_resNext = (r_res >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.r    = r_r;
   assign bus.co   = r_co;
   assign bus.of   = r_of;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_r     <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_op    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_co    <= 1'b0;
         r_of    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  // Subtraction is x + ~y + ~borrow, so only the operand and carry-in are inverted.
                  r_x     <= bus.x;
                  r_b     <= bus.op ? ~bus.y : bus.y;
                  r_carry <= bus.op ? ~bus.ci : bus.ci;
                  r_op    <= bus.op;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_x     <= r_x >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_res   <= w_resNext;
               r_carry <= w_cOut;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_r     <= w_resNext;
                  r_co    <= r_op ? ~w_cOut : w_cOut;
                  r_of    <= w_cMsb ^ w_cOut;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_addsub_serial.sv
// Directed and swept checks of addsub_serial in four (WIDTH,DIGIT) configurations driven in lockstep.
module tb_addsub_serial;
   logic        clk = 1'b0;
   logic        rst;
   logic        tStart;
   logic        tOp;
   logic        tCi;
   logic [15:0] tX;
   logic [15:0] tY;

   int checks = 0;
   int errors = 0;
   int wid[4] = '{8, 8, 16, 12};
   int nDig[4] = '{8, 1, 4, 4};

   always #5 clk = ~clk;

   addsub_serial_if #(.WIDTH(8))  bus0 ();
   addsub_serial_if #(.WIDTH(8))  bus1 ();
   addsub_serial_if #(.WIDTH(16)) bus2 ();
   addsub_serial_if #(.WIDTH(12)) bus3 ();

   addsub_serial #(.WIDTH(8),  .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(bus0));
   addsub_serial #(.WIDTH(8),  .DIGIT(8)) u1 (.clk(clk), .rst(rst), .bus(bus1));
   addsub_serial #(.WIDTH(16), .DIGIT(4)) u2 (.clk(clk), .rst(rst), .bus(bus2));
   addsub_serial #(.WIDTH(12), .DIGIT(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));

   assign bus0.start = tStart; assign bus0.op = tOp; assign bus0.ci = tCi;
   assign bus1.start = tStart; assign bus1.op = tOp; assign bus1.ci = tCi;
   assign bus2.start = tStart; assign bus2.op = tOp; assign bus2.ci = tCi;
   assign bus3.start = tStart; assign bus3.op = tOp; assign bus3.ci = tCi;
   assign bus0.x = tX[7:0];  assign bus0.y = tY[7:0];
   assign bus1.x = tX[7:0];  assign bus1.y = tY[7:0];
   assign bus2.x = tX;       assign bus2.y = tY;
   assign bus3.x = tX[11:0]; assign bus3.y = tY[11:0];

   logic [15:0] oR[4];
   logic        oCo[4];
   logic        oOf[4];
   logic        oDone[4];
   logic        oBusy[4];

   assign oR[0] = {8'h00, bus0.r}; assign oCo[0] = bus0.co; assign oOf[0] = bus0.of;
   assign oR[1] = {8'h00, bus1.r}; assign oCo[1] = bus1.co; assign oOf[1] = bus1.of;
   assign oR[2] = bus2.r;          assign oCo[2] = bus2.co; assign oOf[2] = bus2.of;
   assign oR[3] = {4'h0, bus3.r};  assign oCo[3] = bus3.co; assign oOf[3] = bus3.of;
   assign oDone[0] = bus0.done; assign oBusy[0] = bus0.busy;
   assign oDone[1] = bus1.done; assign oBusy[1] = bus1.busy;
   assign oDone[2] = bus2.done; assign oBusy[2] = bus2.busy;
   assign oDone[3] = bus3.done; assign oBusy[3] = bus3.busy;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Exact-integer reference: wrap, signed range test and unsigned compare, returned as {co, of, r}.
   function automatic logic [17:0] model(input int w, input logic op, input logic ci,
                                         input logic [15:0] x, input logic [15:0] y);
      longint mask, half, xu, yu, xs, ys, c, ex;
      logic   co, of;
      logic [15:0] rv;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      xu   = longint'(x) & mask;
      yu   = longint'(y) & mask;
      xs   = (xu >= half) ? xu - (mask + 1) : xu;
      ys   = (yu >= half) ? yu - (mask + 1) : yu;
      c    = longint'(ci);
      ex   = op ? (xs - ys - c) : (xs + ys + c);
      of   = (ex < -half) || (ex > half - 1);
      co   = op ? (xu < yu + c) : (xu + yu + c > mask);
      rv   = 16'(ex & mask);
      return {co, of, rv};
   endfunction

   function automatic logic [15:0] pickOperand();
      case ($urandom_range(0, 11))
         0: return 16'h8000;
         1: return 16'h7FFF;
         2: return 16'h0080;
         3: return 16'h007F;
         4: return 16'h0800;
         5: return 16'h07FF;
         6: return 16'hFFFF;
         7: return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation on all four units, then watch busy, held r, done count and latency.
   task automatic applyStimulus(input logic op, input logic ci, input logic [15:0] x, input logic [15:0] y);
      logic [17:0] exp[4];
      logic [15:0] prevR[4];
      int          firstDone[4];
      int          dones[4];
      for (int i = 0; i < 4; i++) begin
         exp[i]       = model(wid[i], op, ci, x, y);
         prevR[i]     = oR[i];
         firstDone[i] = -1;
         dones[i]     = 0;
      end
      tOp = op; tCi = ci; tX = x; tY = y; tStart = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         tStart = 1'b0;
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("busy u%0d cycle %0d", i, cyc), 32'(oBusy[i]), 32'(cyc <= nDig[i]));
            if (cyc <= nDig[i])
               checkOutput($sformatf("r held u%0d cycle %0d", i, cyc), 32'(oR[i]), 32'(prevR[i]));
            if (oDone[i]) begin
               dones[i]++;
               if (firstDone[i] < 0) firstDone[i] = cyc;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("done count u%0d", i), 32'(dones[i]), 32'd1);
         checkOutput($sformatf("latency u%0d", i), 32'(firstDone[i]), 32'(nDig[i] + 1));
         checkOutput($sformatf("r u%0d", i), 32'(oR[i]), 32'(exp[i][15:0]));
         checkOutput($sformatf("of u%0d", i), 32'(oOf[i]), 32'(exp[i][16]));
         checkOutput($sformatf("co u%0d", i), 32'(oCo[i]), 32'(exp[i][17]));
      end
   endtask

   task automatic expectHand(input string tag, input logic [7:0] r, input logic co, input logic of);
      checkOutput({tag, " r"}, 32'(oR[0]), 32'(r));
      checkOutput({tag, " co"}, 32'(oCo[0]), 32'(co));
      checkOutput({tag, " of"}, 32'(oOf[0]), 32'(of));
   endtask

   initial begin
      int dones;
      int firstDone;
      logic prevDone;
      logic [15:0] a;
      logic [15:0] b;

      rst = 1'b1; tStart = 1'b0; tOp = 1'b0; tCi = 1'b0; tX = '0; tY = '0;
      tick();
      tick();
      checkOutput("reset busy", 32'(oBusy[0]), 32'd0);
      checkOutput("reset done", 32'(oDone[0]), 32'd0);
      expectHand("reset", 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      applyStimulus(1'b0, 1'b0, 16'd100, 16'd27);
      expectHand("100+27", 8'h7F, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'd100, 16'd28);
      expectHand("100+28", 8'h80, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'd1);
      expectHand("-1+1", 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'hFF80, 16'd1);
      expectHand("-128-1", 8'h7F, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 16'd5, 16'd7);
      expectHand("5-7-1", 8'hFD, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
      applyStimulus(1'b1, 1'b1, 16'h8000, 16'h7FFF);

      // Ignored starts and operand changes during RUN on the 8x1 unit.
      dones = 0; firstDone = -1; prevDone = 1'b0;
      tOp = 1'b0; tCi = 1'b0; tX = 16'd10; tY = 16'd20; tStart = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         tStart = (cyc == 3 || cyc == 5);
         if (cyc == 2) begin tX = 16'h0055; tY = 16'h0011; end
         checkOutput($sformatf("no double done cycle %0d", cyc), 32'(prevDone & oDone[0]), 32'd0);
         if (oDone[0]) begin
            dones++;
            if (firstDone < 0) firstDone = cyc;
         end
         prevDone = oDone[0];
      end
      tStart = 1'b0;
      checkOutput("ignored start done count", 32'(dones), 32'd1);
      checkOutput("ignored start latency", 32'(firstDone), 32'd9);
      expectHand("operands frozen", 8'd30, 1'b0, 1'b0);

      // Start held in the done cycle launches a second operation.
      dones = 0; prevDone = 1'b0;
      tOp = 1'b0; tCi = 1'b0; tX = 16'd3; tY = 16'd4; tStart = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         tick();
         tStart = 1'b0;
         if (cyc == 9) begin
            checkOutput("b2b first done", 32'(oDone[0]), 32'd1);
            checkOutput("b2b first r", 32'(oR[0]), 32'd7);
            tStart = 1'b1; tX = 16'd50; tY = 16'hFFF8;
         end
         if (cyc == 10) begin
            checkOutput("b2b busy after done", 32'(oBusy[0]), 32'd1);
            checkOutput("b2b no done", 32'(oDone[0]), 32'd0);
         end
         if (cyc == 18) begin
            checkOutput("b2b second done", 32'(oDone[0]), 32'd1);
            checkOutput("b2b second r", 32'(oR[0]), 32'd42);
            checkOutput("b2b second co", 32'(oCo[0]), 32'd1);
         end
         checkOutput($sformatf("b2b no double done %0d", cyc), 32'(prevDone & oDone[0]), 32'd0);
         if (oDone[0]) dones++;
         prevDone = oDone[0];
      end
      checkOutput("b2b done count", 32'(dones), 32'd2);

      // Reset in cycle 4 of a RUN aborts with no done afterwards.
      tOp = 1'b0; tCi = 1'b0; tX = 16'd1; tY = 16'd2; tStart = 1'b1;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         tick();
         tStart = 1'b0;
      end
      rst = 1'b1;
      #1;
      checkOutput("mid reset busy", 32'(oBusy[0]), 32'd0);
      checkOutput("mid reset done", 32'(oDone[0]), 32'd0);
      expectHand("mid reset", 8'h00, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      dones = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         if (oDone[0]) dones++;
      end
      checkOutput("no done after reset", 32'(dones), 32'd0);
      applyStimulus(1'b0, 1'b1, 16'd1, 16'd1);
      expectHand("after reset 1+1+1", 8'd3, 1'b0, 1'b0);

      for (int k = 0; k < 1000; k++) begin
         a = pickOperand();
         b = pickOperand();
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
